// File: rtl/module_bus_pkg.sv
// Shared types and constants for the SPI-to-user-module bus bridge.
// State encoding, STATUS word layout and a counter sizing helper.
package module_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_TIMEOUT = 0;
  localparam int FLAG_BADADDR = 1;
  localparam int FLAG_OVERRUN = 2;
  localparam int N_FLAGS      = 3;

  localparam int CNT_LSB  = 8;
  localparam int CNT_MSB  = 15;
  localparam int NMOD_LSB = 16;
  localparam int NMOD_MSB = 19;

  localparam int STATUS_ADDR = 0;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/module_bus_bridge_edge_pulse.sv
// Rising-edge detector: the level is registered once, the pulse is level & ~previous,
// so a held level yields exactly one pulse.
module edge_pulse (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_sig;
  end

  assign o_pulse = i_sig & ~r_prev;

endmodule

// File: rtl/module_bus_bridge.sv
// Bridges SPI register accesses to N user modules: one-cycle write strobes with optional
// ack/timeout, read snapshots, and a STATUS word with sticky W1C error flags.
module module_bus_bridge
  import module_bus_pkg::*;
#(
  parameter int N_MODULES      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int ACK_EN         = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            i_SYSCLK,
  input  logic                            i_RST,
  input  logic                            i_WE,
  input  logic                            i_RD_REQ,
  input  logic [ADDR_WIDTH-1:0]           i_ADDR,
  input  logic [DATA_WIDTH-1:0]           i_WDATA,
  input  logic [DATA_WIDTH*N_MODULES-1:0] i_MODULE_DATA,
  input  logic [N_MODULES-1:0]            i_MODULE_ACK,
  output logic [N_MODULES-1:0]            o_MODULE_WE,
  output logic [DATA_WIDTH-1:0]           o_MODULE_WDATA,
  output logic [DATA_WIDTH-1:0]           o_RDATA,
  output logic                            o_RVALID,
  output logic                            o_WDONE,
  output logic                            o_BUSY,
  output logic                            o_ERR
);

  localparam int IDX_W = cnt_width(N_MODULES - 1);
  localparam int TMO_W = cnt_width(TIMEOUT_CYCLES - 1);
  localparam int SW    = (DATA_WIDTH > 20) ? DATA_WIDTH : 20;

  logic                  w_we_start, w_rd_start;
  logic                  w_is_status, w_is_module, w_ack;
  logic [IDX_W-1:0]      w_addr_idx;
  state_t                r_state, w_state_nxt;
  logic                  w_latch, w_inc;
  logic [TMO_W-1:0]      r_tmo, w_tmo_nxt;
  logic [N_FLAGS-1:0]    r_flags, w_flag_set, w_flag_clr, w_flags_nxt;
  logic [7:0]            r_wcount;
  logic                  r_err, r_rvalid;
  logic [IDX_W-1:0]      r_sel;
  logic [N_MODULES-1:0]  r_module_we;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata, w_rdata_nxt, w_status;
  logic [SW-1:0]         w_status_full;

  edge_pulse u_we_edge (.i_clk(i_SYSCLK), .i_rst(i_RST), .i_sig(i_WE),     .o_pulse(w_we_start));
  edge_pulse u_rd_edge (.i_clk(i_SYSCLK), .i_rst(i_RST), .i_sig(i_RD_REQ), .o_pulse(w_rd_start));

  assign w_is_status = (i_ADDR == ADDR_WIDTH'(STATUS_ADDR));
  assign w_is_module = (i_ADDR != '0) && (i_ADDR <= ADDR_WIDTH'(N_MODULES));
  assign w_addr_idx  = IDX_W'(i_ADDR - ADDR_WIDTH'(1));
  assign w_ack       = i_MODULE_ACK[r_sel];

  always_comb begin
    w_status_full                    = '0;
    w_status_full[N_FLAGS-1:0]       = r_flags;
    w_status_full[CNT_MSB:CNT_LSB]   = r_wcount;
    w_status_full[NMOD_MSB:NMOD_LSB] = 4'(N_MODULES);
  end
  assign w_status = w_status_full[DATA_WIDTH-1:0];

  always_ff @(posedge i_SYSCLK or posedge i_RST) begin
    if (i_RST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // With ACK_EN=0 the strobe cycle stands in for the ack, so done lands one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_inc       = 1'b0;
    w_tmo_nxt   = r_tmo;
    w_flag_set  = '0;
    w_flag_clr  = '0;
    case (r_state)
      IDLE: begin
        if (w_we_start) begin
          if (w_is_module) begin
            w_latch     = 1'b1;
            w_tmo_nxt   = '0;
            w_state_nxt = WAIT;
          end else if (w_is_status) begin
            w_flag_clr  = i_WDATA[N_FLAGS-1:0];
            w_state_nxt = DONE;
          end else begin
            w_flag_set[FLAG_BADADDR] = 1'b1;
            w_state_nxt              = DONE;
          end
        end
      end
      WAIT: begin
        if ((ACK_EN == 0) || w_ack) begin
          w_inc       = 1'b1;
          w_state_nxt = DONE;
        end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          w_flag_set[FLAG_TIMEOUT] = 1'b1;
          w_state_nxt              = DONE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_we_start && (r_state != IDLE)) w_flag_set[FLAG_OVERRUN] = 1'b1;
    if (w_rd_start && !w_is_status && !w_is_module) w_flag_set[FLAG_BADADDR] = 1'b1;
  end

  assign w_flags_nxt = (r_flags & ~w_flag_clr) | w_flag_set;

  always_comb begin
    w_rdata_nxt = '0;
    if (w_is_status)      w_rdata_nxt = w_status;
    else if (w_is_module) w_rdata_nxt = i_MODULE_DATA[w_addr_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge i_SYSCLK or posedge i_RST) begin
    if (i_RST) begin
      r_module_we <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_tmo       <= '0;
      r_wcount    <= '0;
      r_flags     <= '0;
      r_err       <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_module_we <= '0;
      if (w_latch) begin
        r_module_we <= N_MODULES'(1) << w_addr_idx;
        r_wdata     <= i_WDATA;
        r_sel       <= w_addr_idx;
      end
      r_tmo <= w_tmo_nxt;
      if (w_inc) r_wcount <= r_wcount + 8'd1;
      r_flags  <= w_flags_nxt;
      r_err    <= |w_flags_nxt;
      r_rvalid <= w_rd_start;
      if (w_rd_start) r_rdata <= w_rdata_nxt;
    end
  end

  assign o_MODULE_WE    = r_module_we;
  assign o_MODULE_WDATA = r_wdata;
  assign o_RDATA        = r_rdata;
  assign o_RVALID       = r_rvalid;
  assign o_WDONE        = (r_state == DONE);
  assign o_BUSY         = (r_state != IDLE);
  assign o_ERR          = r_err;

endmodule

// File: tb/tb_module_bus_bridge.sv
// Directed bench for module_bus_bridge: ACK_EN=1 instance (a_*) and ACK_EN=0 instance (b_*),
// with strobe and read-data scoreboards checked on the falling edge.
module tb_module_bus_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         we, rd, b_we, b_rd;
  logic [6:0]   addr;
  logic [31:0]  wdata;
  logic [127:0] mdata;
  logic [3:0]   ack, b_ack;

  logic [3:0]  a_mwe, b_mwe;
  logic [31:0] a_mwdata, b_mwdata, a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid, a_wdone, b_wdone, a_busy, b_busy, a_err, b_err;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_wdone_a = 0, n_wdone_b = 0;
  int last_we_a = 0, last_we_b = 0, last_wdone_a = 0, last_wdone_b = 0;
  int ack_cyc = 0;
  int n0 = 0;

  logic [35:0] we_q[$], b_we_q[$];
  logic [31:0] rd_q[$], b_rd_q[$];

  module_bus_bridge #(.ACK_EN(1)) u_dut_a (
    .i_SYSCLK(clk), .i_RST(rst), .i_WE(we), .i_RD_REQ(rd), .i_ADDR(addr), .i_WDATA(wdata),
    .i_MODULE_DATA(mdata), .i_MODULE_ACK(ack), .o_MODULE_WE(a_mwe), .o_MODULE_WDATA(a_mwdata),
    .o_RDATA(a_rdata), .o_RVALID(a_rvalid), .o_WDONE(a_wdone), .o_BUSY(a_busy), .o_ERR(a_err)
  );

  module_bus_bridge #(.ACK_EN(0)) u_dut_b (
    .i_SYSCLK(clk), .i_RST(rst), .i_WE(b_we), .i_RD_REQ(b_rd), .i_ADDR(addr), .i_WDATA(wdata),
    .i_MODULE_DATA(mdata), .i_MODULE_ACK(b_ack), .o_MODULE_WE(b_mwe), .o_MODULE_WDATA(b_mwdata),
    .o_RDATA(b_rdata), .o_RVALID(b_rvalid), .o_WDONE(b_wdone), .o_BUSY(b_busy), .o_ERR(b_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [35:0] e;
    logic [32:0] r;
    if (a_mwe !== 4'h0) begin
      e = '0;
      if (we_q.size() > 0) e = we_q.pop_front();
      check("a_strobe", 64'({a_mwe, a_mwdata}), 64'(e));
      last_we_a = cyc;
    end
    if (a_rvalid) begin
      r = '0;
      if (rd_q.size() > 0) r = {1'b1, rd_q.pop_front()};
      check("a_rdata", 64'({1'b1, a_rdata}), 64'(r));
    end
    if (a_wdone) begin n_wdone_a++; last_wdone_a = cyc; end
    if (b_mwe !== 4'h0) begin
      e = '0;
      if (b_we_q.size() > 0) e = b_we_q.pop_front();
      check("b_strobe", 64'({b_mwe, b_mwdata}), 64'(e));
      last_we_b = cyc;
    end
    if (b_rvalid) begin
      r = '0;
      if (b_rd_q.size() > 0) r = {1'b1, b_rd_q.pop_front()};
      check("b_rdata", 64'({1'b1, b_rdata}), 64'(r));
    end
    if (b_wdone) begin n_wdone_b++; last_wdone_b = cyc; end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wdone(input string tag, input int which, input int budget);
    int start = (which == 0) ? n_wdone_a : n_wdone_b;
    int k = 0;
    while ((((which == 0) ? n_wdone_a : n_wdone_b) == start) && (k < budget)) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(tag, 64'(((which == 0) ? n_wdone_a : n_wdone_b) - start), 64'(1));
  endtask

  task automatic do_read(input int which, input logic [6:0] a, input logic [31:0] exp);
    addr = a;
    if (which == 0) begin rd_q.push_back(exp);   rd = 1'b1;   end
    else            begin b_rd_q.push_back(exp); b_rd = 1'b1; end
    step(1);
    rd = 1'b0;
    b_rd = 1'b0;
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; we = 1'b0; rd = 1'b0; b_we = 1'b0; b_rd = 1'b0;
    addr = '0; wdata = '0; ack = '0; b_ack = '0;
    mdata = {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111};
    @(negedge clk);
    check("rst_mwe",    64'(a_mwe),    64'(0));
    check("rst_mwdata", 64'(a_mwdata), 64'(0));
    check("rst_rdata",  64'(a_rdata),  64'(0));
    check("rst_rvalid", 64'(a_rvalid), 64'(0));
    check("rst_wdone",  64'(a_wdone),  64'(0));
    check("rst_busy",   64'(a_busy),   64'(0));
    check("rst_err",    64'(a_err),    64'(0));
    step(1);
    rst = 1'b0;
    step(2);

    // Write module 0, ack three cycles after the start; WE held high throughout.
    addr = 7'd1; wdata = 32'h12345678;
    we_q.push_back({4'b0001, 32'h12345678});
    we = 1'b1;
    step(3);
    ack = 4'b0001; ack_cyc = cyc;
    step(1);
    ack = '0;
    wait_wdone("t1_wdone", 0, 20);
    check("t1_wdone_lat", 64'(last_wdone_a - ack_cyc), 64'(1));
    we = 1'b0;
    do_read(0, 7'd0, 32'h0004_0100);

    // Timeout on module 3.
    addr = 7'd4; wdata = 32'hCAFEF00D;
    we_q.push_back({4'b1000, 32'hCAFEF00D});
    we = 1'b1;
    step(1);
    we = 1'b0;
    wait_wdone("t2_wdone", 0, 40);
    check("t2_timeout_lat", 64'(last_wdone_a - last_we_a), 64'(16));
    check("t2_err", 64'(a_err), 64'(1));
    do_read(0, 7'd0, 32'h0004_0101);

    // Read sweep and out-of-range read.
    do_read(0, 7'd1, 32'h11111111);
    do_read(0, 7'd2, 32'h22222222);
    do_read(0, 7'd3, 32'h44444444);
    do_read(0, 7'd4, 32'h88888888);
    do_read(0, 7'd9, 32'h0);
    do_read(0, 7'd0, 32'h0004_0103);

    // Overrun during WAIT; a foreign ack must not complete the write.
    addr = 7'd2; wdata = 32'hA5A5A5A5;
    we_q.push_back({4'b0010, 32'hA5A5A5A5});
    we = 1'b1;
    step(1);
    we = 1'b0;
    step(1);
    we = 1'b1;
    step(1);
    we = 1'b0; ack = 4'b1000;
    step(1);
    ack = 4'b0010; ack_cyc = cyc;
    step(1);
    ack = '0;
    wait_wdone("t4_wdone", 0, 20);
    check("t4_wdone_lat", 64'(last_wdone_a - ack_cyc), 64'(1));
    do_read(0, 7'd0, 32'h0004_0207);

    // W1C clear of all flags.
    addr = 7'd0; wdata = 32'h7;
    we = 1'b1;
    step(1);
    we = 1'b0;
    wait_wdone("t4_w1c_wdone", 0, 10);
    check("t4_err_clr", 64'(a_err), 64'(0));
    do_read(0, 7'd0, 32'h0004_0200);

    // Read and write start in the same cycle.
    addr = 7'd3; wdata = 32'h0BADBEEF;
    we_q.push_back({4'b0100, 32'h0BADBEEF});
    rd_q.push_back(32'h44444444);
    we = 1'b1; rd = 1'b1;
    step(1);
    we = 1'b0; rd = 1'b0;
    step(1);
    ack = 4'b0100; ack_cyc = cyc;
    step(1);
    ack = '0;
    wait_wdone("t4b_wdone", 0, 20);
    check("t4b_wdone_lat", 64'(last_wdone_a - ack_cyc), 64'(1));
    do_read(0, 7'd0, 32'h0004_0300);

    // ACK_EN=0 instance: done the cycle after the strobe, no ack.
    addr = 7'd2; wdata = 32'h55AA55AA;
    b_we_q.push_back({4'b0010, 32'h55AA55AA});
    b_we = 1'b1;
    step(1);
    b_we = 1'b0;
    wait_wdone("t5_wdone", 1, 10);
    check("t5_wdone_lat", 64'(last_wdone_b - last_we_b), 64'(1));
    do_read(1, 7'd0, 32'h0004_0100);

    // Reset while waiting for an ack.
    addr = 7'd1; wdata = 32'hDEADBEEF;
    we_q.push_back({4'b0001, 32'hDEADBEEF});
    we = 1'b1;
    step(2);
    check("t6_busy_pre", 64'(a_busy), 64'(1));
    n0 = n_wdone_a;
    rst = 1'b1; we = 1'b0;
    #1;
    check("t6_mwe",    64'(a_mwe),    64'(0));
    check("t6_mwdata", 64'(a_mwdata), 64'(0));
    check("t6_rdata",  64'(a_rdata),  64'(0));
    check("t6_rvalid", 64'(a_rvalid), 64'(0));
    check("t6_wdone",  64'(a_wdone),  64'(0));
    check("t6_busy",   64'(a_busy),   64'(0));
    check("t6_err",    64'(a_err),    64'(0));
    step(2);
    rst = 1'b0;
    step(3);
    check("t6_no_wdone", 64'(n_wdone_a - n0), 64'(0));
    check("t6_idle",     64'(a_busy),         64'(0));
    addr = 7'd1; wdata = 32'h13579BDF;
    we_q.push_back({4'b0001, 32'h13579BDF});
    we = 1'b1;
    step(2);
    ack = 4'b0001; ack_cyc = cyc;
    step(1);
    ack = '0; we = 1'b0;
    wait_wdone("t6_wdone", 0, 20);
    check("t6_wdone_lat", 64'(last_wdone_a - ack_cyc), 64'(1));
    do_read(0, 7'd0, 32'h0004_0100);

    check("we_q_drained",   64'(we_q.size()),   64'(0));
    check("rd_q_drained",   64'(rd_q.size()),   64'(0));
    check("b_we_q_drained", 64'(b_we_q.size()), 64'(0));
    check("b_rd_q_drained", 64'(b_rd_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
